// File: rtl/result_tx_sequencer.sv
// result_tx_sequencer: snapshots the result bus and streams it to
// uart_tx as header, MSB-first data bytes and an 8-bit checksum.
module result_tx_sequencer #(
    parameter int         N_ELEM      = 9,
    parameter int         ELEM_W      = 16,
    parameter bit         HDR_EN      = 1'b1,
    parameter logic [7:0] HDR_BYTE    = 8'hA5,
    parameter bit         CSUM_EN     = 1'b1,
    parameter int         ACK_TIMEOUT = 16
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic [N_ELEM*ELEM_W-1:0]             result,
    input  logic                                 abort,
    input  logic                                 tx_busy,
    output logic [7:0]                           tx_data,
    output logic                                 tx_start,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 err,
    output logic [$clog2(N_ELEM*ELEM_W/8+3)-1:0] byte_cnt
);

    localparam int BPE    = ELEM_W / 8;
    localparam int NDATA  = N_ELEM * BPE;
    localparam int HDR_N  = HDR_EN ? 1 : 0;
    localparam int CSUM_N = CSUM_EN ? 1 : 0;
    localparam int NBYTES = NDATA + HDR_N + CSUM_N;
    localparam int CW     = $clog2(NDATA + 3);
    localparam int AW     = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_ACK,
        WAIT_DONE,
        NEXT
    } state_t;

    state_t                   state;
    logic [N_ELEM*ELEM_W-1:0] snap;
    logic [7:0]               csum;
    logic [AW-1:0]            ack_cnt;
    logic [7:0]               snap_b [NDATA];
    logic [CW-1:0]            dix;
    logic                     is_hdr;
    logic                     is_data;
    logic [7:0]               cur_byte;
    logic [7:0]               first_byte;

    // Byte view of the snapshot in transmit order (element MSB first)
    for (genvar e = 0; e < N_ELEM; e++) begin : g_elem
        for (genvar b = 0; b < BPE; b++) begin : g_byte
            assign snap_b[e*BPE+b] = snap[e*ELEM_W + (BPE-1-b)*8 +: 8];
        end
    end

    assign dix        = byte_cnt - CW'(HDR_N);
    assign is_hdr     = HDR_EN && (byte_cnt == '0);
    assign is_data    = !is_hdr && (dix < CW'(NDATA));
    assign first_byte = HDR_EN ? HDR_BYTE : result[ELEM_W-1 -: 8];

    // Byte selected by the count of bytes already completed
    always_comb begin
        cur_byte = csum;
        if (is_hdr) begin
            cur_byte = HDR_BYTE;
        end else if (is_data) begin
            cur_byte = snap_b[dix];
        end
    end

    // Frame sequencer with uart_tx start/busy handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            snap     <= '0;
            csum     <= '0;
            ack_cnt  <= '0;
            tx_data  <= '0;
            tx_start <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            byte_cnt <= '0;
        end else begin
            tx_start <= 1'b0;
            done     <= 1'b0;
            if (state != IDLE && abort) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (start && !abort) begin
                            snap     <= result;
                            csum     <= '0;
                            byte_cnt <= '0;
                            err      <= 1'b0;
                            busy     <= 1'b1;
                            tx_data  <= first_byte;
                            state    <= ISSUE;
                        end
                    end
                    ISSUE: begin
                        tx_data <= cur_byte;
                        if (!tx_busy) begin
                            tx_start <= 1'b1;
                            ack_cnt  <= '0;
                            state    <= WAIT_ACK;
                        end
                    end
                    WAIT_ACK: begin
                        if (tx_busy) begin
                            state <= WAIT_DONE;
                        end else if (ack_cnt == AW'(ACK_TIMEOUT - 1)) begin
                            err   <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            ack_cnt <= ack_cnt + 1'b1;
                        end
                    end
                    WAIT_DONE: begin
                        if (!tx_busy) begin
                            byte_cnt <= byte_cnt + 1'b1;
                            if (is_data) begin
                                csum <= csum + tx_data;
                            end
                            state <= NEXT;
                        end
                    end
                    NEXT: begin
                        if (byte_cnt == CW'(NBYTES)) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            tx_data <= cur_byte;
                            state   <= ISSUE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_result_tx_sequencer.sv
// tb_result_tx_sequencer: directed scenarios against a uart_tx model
// that holds tx_busy for 10 cycles per byte.
module tb_result_tx_sequencer;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [143:0] result;
    logic         abort;
    logic         tx_busy;
    logic [7:0]   tx_data;
    logic         tx_start;
    logic         busy;
    logic         done;
    logic         err;
    logic [4:0]   byte_cnt;

    int         checks = 0;
    int         errors = 0;
    int         done_cnt = 0;
    int         start_cnt = 0;
    int         glitch = 0;
    int         bleft;
    bit         uart_en = 1'b1;
    logic [7:0] cap_q[$];

    result_tx_sequencer dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .result   (result),
        .abort    (abort),
        .tx_busy  (tx_busy),
        .tx_data  (tx_data),
        .tx_start (tx_start),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .byte_cnt (byte_cnt)
    );

    always #5 clk = ~clk;

    // uart_tx model: captures bytes and counts strobes 1ns after each edge
    initial begin
        tx_busy = 1'b0;
        bleft   = 0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                tx_busy = 1'b0;
                bleft   = 0;
            end else begin
                if (done) done_cnt++;
                if (tx_start) start_cnt++;
                if (bleft > 0) begin
                    bleft--;
                    if (bleft == 0) tx_busy = 1'b0;
                end else if (tx_start && uart_en) begin
                    cap_q.push_back(tx_data);
                    tx_busy = 1'b1;
                    bleft   = 10;
                end
            end
        end
    end

    always @(posedge tx_start) if (rst) glitch++;

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; abort = 1'b0; result = '0;
        #12;
        checks++;
        if ({tx_data, tx_start, busy, done, err, byte_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h required 0",
                     {tx_data, tx_start, busy, done, err, byte_cnt});
        end
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({tx_data, tx_start, busy, done, err, byte_cnt} !== '0) begin
            errors++;
            $display("FAIL post_reset_idle: got %h required 0",
                     {tx_data, tx_start, busy, done, err, byte_cnt});
        end
    endtask

    task automatic test_normal;
        logic [7:0] exp[$];
        int n;
        int d0;
        exp.push_back(8'hA5);
        for (int i = 0; i < 9; i++) begin
            result[i*16 +: 16] = 16'(i + 1);
            exp.push_back(8'h00);
            exp.push_back(8'(i + 1));
        end
        exp.push_back(8'h2D);
        cap_q.delete();
        d0 = done_cnt;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        checks++;
        if (busy !== 1'b1 || tx_start !== 1'b0) begin
            errors++;
            $display("FAIL normal_issue: busy=%b tx_start=%b required 1,0",
                     busy, tx_start);
        end
        @(negedge clk);
        checks++;
        if (tx_start !== 1'b1 || tx_data !== 8'hA5) begin
            errors++;
            $display("FAIL normal_first_start: tx_start=%b data=%h required 1,a5",
                     tx_start, tx_data);
        end
        n = 0;
        while (!(cap_q.size() == 20 && !tx_busy) && n < 3000) begin
            @(negedge clk); n++;
        end
        checks++;
        if (n >= 3000) begin
            errors++;
            $display("FAIL normal_wait: got %0d bytes required 20", cap_q.size());
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL normal_done_early: done=%b required 0", done);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || byte_cnt !== 5'd20 || err !== 1'b0) begin
            errors++;
            $display("FAIL normal_done: done=%b busy=%b cnt=%0d err=%b required 1,0,20,0",
                     done, busy, byte_cnt, err);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || byte_cnt !== 5'd20) begin
            errors++;
            $display("FAIL normal_done_pulse: done=%b cnt=%0d required 0,20",
                     done, byte_cnt);
        end
        checks++;
        if (cap_q.size() != 20 || done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL normal_count: bytes=%0d dones=%0d required 20,1",
                     cap_q.size(), done_cnt - d0);
        end
        for (int i = 0; i < 20 && i < cap_q.size(); i++) begin
            checks++;
            if (cap_q[i] !== exp[i]) begin
                errors++;
                $display("FAIL normal_byte%0d: got %h required %h", i, cap_q[i], exp[i]);
            end
        end
    endtask

    task automatic test_csum_wrap;
        int n;
        result = {144{1'b1}};
        cap_q.delete();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        n = 0;
        while (!done && n < 3000) begin
            @(negedge clk); n++;
        end
        checks++;
        if (n >= 3000 || cap_q.size() != 20) begin
            errors++;
            $display("FAIL wrap_frame: got %0d bytes required 20", cap_q.size());
        end
        for (int i = 1; i < 19 && i < cap_q.size(); i++) begin
            checks++;
            if (cap_q[i] !== 8'hFF) begin
                errors++;
                $display("FAIL wrap_byte%0d: got %h required ff", i, cap_q[i]);
            end
        end
        checks++;
        if (cap_q.size() < 20 || cap_q[19] !== 8'hEE) begin
            errors++;
            $display("FAIL wrap_csum: got %h required ee",
                     cap_q.size() < 20 ? 8'h00 : cap_q[19]);
        end
        @(negedge clk);
    endtask

    task automatic test_timeout;
        int n;
        int d0;
        int s0;
        uart_en = 1'b0;
        d0 = done_cnt;
        s0 = start_cnt;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        n = 0;
        while (!tx_start && n < 50) begin
            @(negedge clk); n++;
        end
        checks++;
        if (n >= 50) begin
            errors++;
            $display("FAIL timeout_start: tx_start=%b required 1", tx_start);
        end
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            checks++;
            if (k < 16 && (err !== 1'b0 || busy !== 1'b1)) begin
                errors++;
                $display("FAIL timeout_early%0d: err=%b busy=%b required 0,1", k, err, busy);
            end else if (k == 16 && (err !== 1'b1 || busy !== 1'b0)) begin
                errors++;
                $display("FAIL timeout_flag: err=%b busy=%b required 1,0", err, busy);
            end
        end
        repeat (20) @(negedge clk);
        checks++;
        if (start_cnt - s0 != 1 || done_cnt != d0 || err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_after: starts=%0d dones=%0d err=%b required 1,0,1",
                     start_cnt - s0, done_cnt - d0, err);
        end
        uart_en = 1'b1;
    endtask

    task automatic test_back_to_back;
        logic [7:0] exp[$];
        int n;
        int d0;
        exp.push_back(8'hA5);
        for (int i = 0; i < 9; i++) begin
            result[i*16 +: 16] = {8'(8'h10 + i), 8'(8'h20 + i)};
            exp.push_back(8'(8'h10 + i));
            exp.push_back(8'(8'h20 + i));
        end
        exp.push_back(8'hF8);
        cap_q.delete();
        d0 = done_cnt;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        checks++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_err_clear: err=%b busy=%b required 0,1", err, busy);
        end
        n = 0;
        while (cap_q.size() < 5 && n < 1000) begin
            @(negedge clk); n++;
        end
        result = '0;
        repeat (3) begin
            start = 1'b1;
            @(negedge clk); start = 1'b0;
            repeat (7) @(negedge clk);
        end
        n = 0;
        while (!done && n < 3000) begin
            @(negedge clk); n++;
        end
        repeat (40) @(negedge clk);
        checks++;
        if (cap_q.size() != 20 || done_cnt - d0 != 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_count: bytes=%0d dones=%0d busy=%b required 20,1,0",
                     cap_q.size(), done_cnt - d0, busy);
        end
        for (int i = 0; i < 20 && i < cap_q.size(); i++) begin
            checks++;
            if (cap_q[i] !== exp[i]) begin
                errors++;
                $display("FAIL b2b_byte%0d: got %h required %h", i, cap_q[i], exp[i]);
            end
        end
    endtask

    task automatic test_abort;
        int n;
        int d0;
        int s0;
        for (int i = 0; i < 9; i++) result[i*16 +: 16] = 16'(i + 1);
        s0 = start_cnt;
        @(negedge clk); start = 1'b1; abort = 1'b1;
        @(negedge clk); start = 1'b0; abort = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || start_cnt != s0) begin
            errors++;
            $display("FAIL abort_vs_start: busy=%b starts=%0d required 0,0",
                     busy, start_cnt - s0);
        end
        cap_q.delete();
        d0 = done_cnt;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        n = 0;
        while (!(cap_q.size() == 8 && byte_cnt == 5'd7) && n < 2000) begin
            @(negedge clk); n++;
        end
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || byte_cnt !== 5'd7) begin
            errors++;
            $display("FAIL abort_idle: busy=%b done=%b err=%b cnt=%0d required 0,0,0,7",
                     busy, done, err, byte_cnt);
        end
        s0 = start_cnt;
        repeat (12) @(negedge clk);
        checks++;
        if (done_cnt != d0 || start_cnt != s0 || tx_busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_quiet: dones=%0d starts=%0d txb=%b required 0,0,0",
                     done_cnt - d0, start_cnt - s0, tx_busy);
        end
        cap_q.delete();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        n = 0;
        while (!done && n < 3000) begin
            @(negedge clk); n++;
        end
        checks++;
        if (cap_q.size() != 20 || done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL abort_restart: bytes=%0d dones=%0d required 20,1",
                     cap_q.size(), done_cnt - d0);
        end
        checks++;
        if (cap_q.size() < 20 || cap_q[0] !== 8'hA5 || cap_q[8] !== 8'h04 ||
            cap_q[19] !== 8'h2D) begin
            errors++;
            $display("FAIL abort_restart_bytes: hdr=%h b8=%h csum=%h required a5,04,2d",
                     cap_q.size() > 0 ? cap_q[0] : 8'h00,
                     cap_q.size() > 8 ? cap_q[8] : 8'h00,
                     cap_q.size() > 19 ? cap_q[19] : 8'h00);
        end
        @(negedge clk);
    endtask

    task automatic test_async_reset;
        int n;
        uart_en = 1'b0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        n = 0;
        while (!tx_start && n < 50) begin
            @(negedge clk); n++;
        end
        @(posedge clk);
        #3;
        checks++;
        if (busy !== 1'b1 || tx_data !== 8'hA5) begin
            errors++;
            $display("FAIL areset_pre: busy=%b data=%h required 1,a5", busy, tx_data);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({tx_data, tx_start, busy, done, err, byte_cnt} !== '0) begin
            errors++;
            $display("FAIL areset_immediate: got %h required 0",
                     {tx_data, tx_start, busy, done, err, byte_cnt});
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        uart_en = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (glitch != 0 || tx_start !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL areset_after: glitch=%0d tx_start=%b busy=%b required 0,0,0",
                     glitch, tx_start, busy);
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_csum_wrap();
        test_timeout();
        test_back_to_back();
        test_abort();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
